// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with issue/writeback busy scoreboard
module regfile_mp #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rs_addr,
    output logic [NUM_RD*XLEN-1:0]   rs_data,
    output logic [NUM_RD-1:0]        rs_busy,
    input  logic [NUM_WR-1:0]        rd_write,
    input  logic [NUM_WR*AW-1:0]     rd_addr,
    input  logic [NUM_WR*XLEN-1:0]   rd_data,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    output logic [NREGS-1:0]         busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next state: writebacks in port order so the highest port wins, then issue set overrides clears
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (rd_write[j] && (rd_addr[j*AW +: AW] != '0)) begin
                regs_d[rd_addr[j*AW +: AW]] = rd_data[j*XLEN +: XLEN];
                busy_d[rd_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // State register; reset discards any write or issue presented in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Combinational read ports with optional same-cycle forwarding from writeback
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rbusy;

        assign ra = rs_addr[i*AW +: AW];

        // Stored value first, then later write ports override earlier ones; x0 forced last
        always_comb begin
            rdat  = regs_q[ra];
            rbusy = busy_q[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (rd_write[j] && (rd_addr[j*AW +: AW] == ra)) begin
                        rdat  = rd_data[j*XLEN +: XLEN];
                        rbusy = 1'b0;
                    end
                end
            end
            if (ra == '0) begin
                rdat  = '0;
                rbusy = 1'b0;
            end
        end

        assign rs_data[i*XLEN +: XLEN] = rdat;
        assign rs_busy[i]              = rbusy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: BYPASS=0, one write port
    logic         a_rst;
    logic [9:0]   a_rs_addr;
    logic [127:0] a_rs_data;
    logic [1:0]   a_rs_busy;
    logic [0:0]   a_rd_write;
    logic [4:0]   a_rd_addr;
    logic [63:0]  a_rd_data;
    logic         a_issue_valid;
    logic [4:0]   a_issue_rd;
    logic [31:0]  a_busy_vec;

    // Instance B: BYPASS=1, two write ports
    logic         b_rst;
    logic [9:0]   b_rs_addr;
    logic [127:0] b_rs_data;
    logic [1:0]   b_rs_busy;
    logic [1:0]   b_rd_write;
    logic [9:0]   b_rd_addr;
    logic [127:0] b_rd_data;
    logic         b_issue_valid;
    logic [4:0]   b_issue_rd;
    logic [31:0]  b_busy_vec;

    regfile_mp #(.XLEN(64), .NREGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)) u_a (
        .clk         (clk),
        .rst         (a_rst),
        .rs_addr     (a_rs_addr),
        .rs_data     (a_rs_data),
        .rs_busy     (a_rs_busy),
        .rd_write    (a_rd_write),
        .rd_addr     (a_rd_addr),
        .rd_data     (a_rd_data),
        .issue_valid (a_issue_valid),
        .issue_rd    (a_issue_rd),
        .busy_vec    (a_busy_vec)
    );

    regfile_mp #(.XLEN(64), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_b (
        .clk         (clk),
        .rst         (b_rst),
        .rs_addr     (b_rs_addr),
        .rs_data     (b_rs_data),
        .rs_busy     (b_rs_busy),
        .rd_write    (b_rd_write),
        .rd_addr     (b_rd_addr),
        .rd_data     (b_rd_data),
        .issue_valid (b_issue_valid),
        .issue_rd    (b_issue_rd),
        .busy_vec    (b_busy_vec)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_rd_write = '0; a_rd_addr = '0; a_rd_data = '0; a_issue_valid = 1'b0; a_issue_rd = '0;
        b_rd_write = '0; b_rd_addr = '0; b_rd_data = '0; b_issue_valid = 1'b0; b_issue_rd = '0;
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_rs_addr = '0; b_rs_addr = '0;
        idle_inputs();

        // Reset for two cycles
        tick();
        tick();
        a_rst = 1'b0; b_rst = 1'b0;
        #1;

        // All addresses read zero and not busy after reset
        for (int i = 0; i < 32; i++) begin
            a_rs_addr = {5'(31 - i), 5'(i)};
            b_rs_addr = {5'(31 - i), 5'(i)};
            #1;
            chk($sformatf("rst_a_p0_x%0d", i), a_rs_data[63:0], 64'h0);
            chk($sformatf("rst_a_p1_x%0d", 31 - i), a_rs_data[127:64], 64'h0);
            chk($sformatf("rst_b_p0_x%0d", i), b_rs_data[63:0], 64'h0);
            chk($sformatf("rst_a_busy_x%0d", i), 64'(a_rs_busy), 64'h0);
            chk($sformatf("rst_b_busy_x%0d", i), 64'(b_rs_busy), 64'h0);
        end
        chk("rst_a_busy_vec", 64'(a_busy_vec), 64'h0);
        chk("rst_b_busy_vec", 64'(b_busy_vec), 64'h0);

        // Write to x0 is dropped, also not forwarded
        a_rd_write = 1'b1; a_rd_addr = 5'd0; a_rd_data = 64'hDEAD;
        b_rd_write = 2'b01; b_rd_addr = {5'd0, 5'd0}; b_rd_data = {64'h0, 64'hDEAD};
        a_rs_addr = {5'd0, 5'd0}; b_rs_addr = {5'd0, 5'd0};
        #1;
        chk("x0_b_bypass_blocked", b_rs_data[63:0], 64'h0);
        tick();
        idle_inputs();
        #1;
        chk("x0_a_read", a_rs_data[63:0], 64'h0);
        chk("x0_b_read", b_rs_data[63:0], 64'h0);

        // BYPASS=0: write x5 is invisible in its own cycle, visible next cycle
        a_rd_write = 1'b1; a_rd_addr = 5'd5; a_rd_data = 64'h1234_5678_9ABC_DEF0;
        a_rs_addr = {5'd0, 5'd5};
        #1;
        chk("a_x5_same_cycle", a_rs_data[63:0], 64'h0);
        tick();
        idle_inputs();
        #1;
        chk("a_x5_next_cycle", a_rs_data[63:0], 64'h1234_5678_9ABC_DEF0);

        // BYPASS=0: busy is not forced low by a same-cycle writeback
        a_issue_valid = 1'b1; a_issue_rd = 5'd9;
        tick();
        idle_inputs();
        a_rs_addr = {5'd5, 5'd9};
        #1;
        chk("a_x9_busy_vec", 64'(a_busy_vec), 64'h0000_0200);
        chk("a_x9_rs_busy", 64'(a_rs_busy), 64'h1);
        a_rd_write = 1'b1; a_rd_addr = 5'd9; a_rd_data = 64'h55;
        #1;
        chk("a_x9_wb_rs_busy_unforced", 64'(a_rs_busy), 64'h1);
        chk("a_x9_wb_data_old", a_rs_data[63:0], 64'h0);
        tick();
        idle_inputs();
        #1;
        chk("a_x9_after_wb_busy", 64'(a_rs_busy), 64'h0);
        chk("a_x9_after_wb_data", a_rs_data[63:0], 64'h55);

        // BYPASS=1: write-write conflict on x7, highest port wins
        b_rd_write = 2'b11; b_rd_addr = {5'd7, 5'd7}; b_rd_data = {64'h22, 64'h11};
        b_rs_addr = {5'd5, 5'd7};
        #1;
        chk("b_x7_bypass_conflict", b_rs_data[63:0], 64'h22);
        chk("b_x5_unrelated", b_rs_data[127:64], 64'h0);
        tick();
        idle_inputs();
        #1;
        chk("b_x7_stored", b_rs_data[63:0], 64'h22);

        // Scoreboard: issue x9, then writeback clears busy with bypassed data
        b_issue_valid = 1'b1; b_issue_rd = 5'd9;
        tick();
        idle_inputs();
        b_rs_addr = {5'd9, 5'd9};
        #1;
        chk("b_x9_busy_vec", 64'(b_busy_vec), 64'h0000_0200);
        chk("b_x9_rs_busy", 64'(b_rs_busy), 64'h3);
        b_rd_write = 2'b10; b_rd_addr = {5'd9, 5'd0}; b_rd_data = {64'h55, 64'h0};
        #1;
        chk("b_x9_wb_rs_busy", 64'(b_rs_busy), 64'h0);
        chk("b_x9_wb_bypass", b_rs_data[63:0], 64'h55);
        chk("b_x9_wb_busy_vec_reg", 64'(b_busy_vec), 64'h0000_0200);
        tick();
        idle_inputs();
        #1;
        chk("b_x9_after_busy_vec", 64'(b_busy_vec), 64'h0);
        chk("b_x9_after_data", b_rs_data[127:64], 64'h55);

        // Issue to x0 has no effect
        b_issue_valid = 1'b1; b_issue_rd = 5'd0;
        tick();
        idle_inputs();
        #1;
        chk("b_issue_x0", 64'(b_busy_vec), 64'h0);

        // Set/clear collision on x3: set wins, data written
        b_issue_valid = 1'b1; b_issue_rd = 5'd3;
        tick();
        b_rd_write = 2'b01; b_rd_addr = {5'd0, 5'd3}; b_rd_data = {64'h0, 64'h77};
        b_rs_addr = {5'd0, 5'd3};
        #1;
        chk("b_x3_collide_rs_busy", 64'(b_rs_busy), 64'h0);
        tick();
        idle_inputs();
        #1;
        chk("b_x3_collide_busy_vec", 64'(b_busy_vec), 64'h0000_0008);
        chk("b_x3_collide_data", b_rs_data[63:0], 64'h77);
        chk("b_x3_collide_rs_busy_next", 64'(b_rs_busy), 64'h1);

        // Fill x1..x4 with data and make them busy
        b_rd_write = 2'b11; b_rd_addr = {5'd2, 5'd1}; b_rd_data = {64'hA2, 64'hA1};
        b_issue_valid = 1'b1; b_issue_rd = 5'd1;
        tick();
        b_rd_addr = {5'd4, 5'd3}; b_rd_data = {64'hA4, 64'hA3};
        b_issue_rd = 5'd2;
        tick();
        b_rd_write = 2'b00;
        b_issue_rd = 5'd3;
        tick();
        b_issue_rd = 5'd4;
        tick();
        idle_inputs();
        b_rs_addr = {5'd4, 5'd2};
        #1;
        chk("b_fill_busy_vec", 64'(b_busy_vec), 64'h0000_001E);
        chk("b_fill_x2", b_rs_data[63:0], 64'hA2);
        chk("b_fill_x4", b_rs_data[127:64], 64'hA4);

        // Reset mid-operation with a write to x2 and an issue: everything discarded
        b_rst = 1'b1;
        b_rd_write = 2'b01; b_rd_addr = {5'd0, 5'd2}; b_rd_data = {64'h0, 64'h99};
        b_issue_valid = 1'b1; b_issue_rd = 5'd6;
        tick();
        b_rst = 1'b0;
        idle_inputs();
        #1;
        chk("b_midrst_busy_vec", 64'(b_busy_vec), 64'h0);
        for (int i = 1; i <= 7; i++) begin
            b_rs_addr = {5'd0, 5'(i)};
            #1;
            chk($sformatf("b_midrst_x%0d", i), b_rs_data[63:0], 64'h0);
            chk($sformatf("b_midrst_busy_x%0d", i), 64'(b_rs_busy), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the superscalar core; successor to the single-write, two-read register file.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with optional same-cycle write-to-read bypass.
- Includes a per-register busy scoreboard: set at issue, cleared at writeback. Decode uses it to stall on RAW hazards.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers (power of 2, ≥2). AW = $clog2(NREGS) is derived locally.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write (writeback) ports.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads; when 0 reads see only the stored value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs_addr  in  NUM_RD*AW  read addresses; port i is bits [i*AW +: AW].
- rs_data  out  NUM_RD*XLEN  read data, port i.
- rs_busy  out  NUM_RD  port i source register has a pending producer.
- rd_write  in  NUM_WR  write enable, port j.
- rd_addr  in  NUM_WR*AW  write address, port j.
- rd_data  in  NUM_WR*XLEN  write data, port j.
- issue_valid  in  1  an instruction with a destination register issues this cycle.
- issue_rd  in  AW  destination of the issuing instruction.
- busy_vec  out  NREGS  raw scoreboard state; bit 0 always 0.

Behaviour:
- Storage: NREGS x XLEN flops plus an NREGS-bit busy vector.
- Reset: when rst=1 at a clock edge, all registers clear to 0 and all busy bits clear to 0. Writes and issues in that cycle are ignored. Reset asserted mid-operation discards all pending state.
- After reset, every rs_data reads 0, every rs_busy is 0, and busy_vec is 0.
- Write: on the edge with rd_write[j]=1 and rd_addr[j]≠0, rd_data[j] is stored. Writes to address 0 are dropped.
- Write-write conflict: when several ports write the same address in one cycle, the highest-index port j wins.
- Read path is combinational, zero latency.
  - rs_addr=0 returns 0 and rs_busy=0, regardless of any activity.
  - BYPASS=1: if any write port targets rs_addr≠0 this cycle, rs_data returns that write's data (highest j on conflict). Otherwise it returns the stored value.
  - BYPASS=0: rs_data returns the stored value only. New data is visible the cycle after the write.
- Scoreboard:
  - issue_valid=1 with issue_rd≠0 sets busy[issue_rd] at the edge. Issuing to register 0 has no effect.
  - A write on port j with rd_addr[j]≠0 clears busy[rd_addr[j]] at the edge.
  - Simultaneous set and clear of the same register: set wins. The writeback belongs to the older producer; the new producer stays pending. The data is still written.
  - A write to a non-busy register is legal; busy stays 0.
  - Multiple clears of the same register in one cycle are legal.
- rs_busy[i]:
  - Equals busy[rs_addr[i]].
  - With BYPASS=1, it is forced to 0 when a same-cycle write targets that address, unless issue_valid/issue_rd sets it the same cycle (the set is not visible until the next cycle, so rs_busy is 0 in that cycle).
  - With BYPASS=0, no forcing is applied.
- busy_vec reflects registered state only; no bypass is applied.
- No stalls, no backpressure, no internal FSM beyond the busy bits. All inputs are sampled every cycle.

Test Plan:
- Reset and x0 (defaults):
  - Drive rst for 2 cycles, then read all 32 addresses → all data 0, busy_vec=0.
  - Write 0xDEAD to x0 → subsequent read of x0 returns 0.
- Write and read, BYPASS=0:
  - Write x5=0x1234_5678_9ABC_DEF0 at cycle t; read x5 in cycle t → old value 0.
  - Read x5 in cycle t+1 → 0x1234_5678_9ABC_DEF0.
- Bypass, BYPASS=1, NUM_WR=2:
  - Same cycle, port0 writes x7=0x11 and port1 writes x7=0x22, read x7 that cycle → 0x22.
  - Next cycle the stored value is 0x22.
- Scoreboard:
  - Issue rd=x9 → busy_vec[9]=1 next cycle, rs_busy=1 for reads of x9.
  - Write x9=0x55 → busy clears and data reads 0x55. With BYPASS=1, rs_busy=0 already in the writeback cycle.
- Set-clear collision: with x3 busy, issue_rd=x3 and a write to x3=0x77 in the same cycle → busy_vec[3] stays 1, stored x3=0x77.
- Reset mid-operation:
  - Registers x1..x4 hold nonzero values and are busy.
  - Assert rst together with a write to x2=0x99 → all data 0, busy_vec=0, write discarded.
